// File: rtl/fir_fifo_pkg.sv
// ----------------------------------------------------------------------------
// fir_fifo_pkg
// Shared types and constants for the FIR sample-FIFO read-side logic.
//   drain_state_t : read sequencer states (IDLE, RUN, DRAIN)
//   DEF_DWIDTH    : default sample width
//   DEF_BLK_LEN   : default samples per block
//   MAX_RD_LAT    : largest supported FIFO RAM read latency
//   CRED_W        : width that holds occupancy + in-flight reads at MAX_RD_LAT
// ----------------------------------------------------------------------------
package fir_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } drain_state_t;

  localparam int unsigned DEF_DWIDTH  = 8;
  localparam int unsigned DEF_BLK_LEN = 16;
  localparam int unsigned MAX_RD_LAT  = 3;

  // Buffer depth is at most MAX_RD_LAT+1 and at most MAX_RD_LAT reads are in
  // flight, so the credit sum never exceeds 2*MAX_RD_LAT+1.
  localparam int unsigned CRED_W = $clog2(2 * MAX_RD_LAT + 2);

endpackage

// File: rtl/drain_skid_buf.sv
// ----------------------------------------------------------------------------
// drain_skid_buf
// FIFO-ordered register buffer that absorbs the FIFO RAM read latency.
// Entry 0 is always the head, so the output is a plain register read.
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_push, i_data : write one sample (caller guarantees it is never full)
//   i_pop          : remove the head sample (caller guarantees not empty)
//   o_occ          : number of stored samples
//   o_valid        : buffer non-empty
//   o_data         : head sample
// ----------------------------------------------------------------------------
module drain_skid_buf #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_push,
  input  logic [DWIDTH-1:0]            i_data,
  input  logic                         i_pop,
  output logic [$clog2(DEPTH+1)-1:0]   o_occ,
  output logic                         o_valid,
  output logic [DWIDTH-1:0]            o_data
);

  localparam int unsigned OCCW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][DWIDTH-1:0] r_mem;
  logic [DEPTH-1:0][DWIDTH-1:0] w_mem_nxt;
  logic [OCCW-1:0]              r_occ;
  logic [OCCW-1:0]              w_wr_idx;

  // A push lands just behind the last entry that survives this cycle's pop,
  // which keeps ordering intact when push and pop coincide.
  assign w_wr_idx = r_occ - OCCW'(i_pop);

  always_comb begin
    // NOTE: every always_comb output gets a default first; no path can leave
    // it unassigned, so no latch is inferred.
    w_mem_nxt = r_mem;
    if (i_pop) begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) w_mem_nxt[i] = r_mem[i+1];
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (i_push && (w_wr_idx == OCCW'(i))) w_mem_nxt[i] = i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!i_rst_n) begin
      // NOTE: storage is reset as well, so o_data reads zero after reset
      // instead of leftover samples.
      r_mem <= '0;
      r_occ <= '0;
    end else begin
      r_mem <= w_mem_nxt;
      r_occ <= r_occ + OCCW'(i_push) - OCCW'(i_pop);
    end
  end

  assign o_occ   = r_occ;
  assign o_valid = (r_occ != '0);
  assign o_data  = r_mem[0];

endmodule

// File: rtl/fifo_drain_ctrl.sv
// ----------------------------------------------------------------------------
// fifo_drain_ctrl
// Read-side sequencer for the dual-clock FIR sample FIFO (read clock domain).
// Issues FIFO reads against a credit limit, tracks reads in flight through a
// RD_LAT-deep tag pipe, buffers returning samples in drain_skid_buf and frames
// the output stream into blocks of BLK_LEN samples.
// Ports:
//   rd_clk      : FIFO read clock
//   areset_n    : active-low reset, sampled synchronously on rd_clk
//   enable      : run request
//   fifo_empty  : FIFO empty flag
//   fifo_read   : FIFO read strobe
//   fifo_q      : FIFO read data, valid RD_LAT cycles after fifo_read
//   out_valid / out_ready / out_data / out_last : sample stream to MAC core
//   blk_cnt     : completed blocks (wraps)
//   busy        : sequencer in RUN or DRAIN
// Optional build macro DRAIN_STATS_EN adds:
//   stats_clr   : synchronous clear of starve_cnt
//   starve_cnt  : saturating count of RUN cycles where the core waited on us
// ----------------------------------------------------------------------------
module fifo_drain_ctrl
  import fir_fifo_pkg::*;
#(
  parameter int unsigned DWIDTH  = DEF_DWIDTH,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned BLK_LEN = DEF_BLK_LEN,
  parameter int unsigned CNTW    = 16
) (
  input  logic              rd_clk,
  input  logic              areset_n,
  input  logic              enable,
  input  logic              fifo_empty,
  output logic              fifo_read,
  input  logic [DWIDTH-1:0] fifo_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_last,
  output logic [CNTW-1:0]   blk_cnt,
  output logic              busy
`ifdef DRAIN_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [15:0]       starve_cnt
`endif
);

  localparam int unsigned DEPTH = RD_LAT + 1;
  localparam int unsigned OCCW  = $clog2(DEPTH + 1);
  localparam logic [15:0] LAST_IDX = 16'(BLK_LEN - 1);

  drain_state_t      r_state;
  drain_state_t      w_state_nxt;
  logic [RD_LAT-1:0] r_tag;
  logic [15:0]       r_idx;
  logic [CNTW-1:0]   r_blk_cnt;
  logic [OCCW-1:0]   w_occ;
  logic [CRED_W-1:0] w_inflight;
  logic [CRED_W-1:0] w_credit;
  logic              w_pop;
  logic              w_push;
  logic              w_read;
  logic              w_last;

  assign w_pop  = out_valid & out_ready;
  assign w_push = r_tag[RD_LAT-1];

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < int'(RD_LAT); i++) w_inflight = w_inflight + CRED_W'(r_tag[i]);
  end

  // Slots already claimed once this cycle's pop leaves. A pop can only happen
  // with occupancy >= 1, so this never underflows.
  assign w_credit = CRED_W'(w_occ) + w_inflight - CRED_W'(w_pop);
  assign w_read   = (r_state == RUN) && !fifo_empty && (w_credit < CRED_W'(DEPTH));
  assign fifo_read = w_read;

  // Clearing the tags on reset is what discards data still returning from RAM.
  always_ff @(posedge rd_clk) begin
    if (!areset_n) begin
      r_tag <= '0;
    end else begin
      r_tag[0] <= w_read;
      for (int i = 1; i < int'(RD_LAT); i++) r_tag[i] <= r_tag[i-1];
    end
  end

  drain_skid_buf #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH)
  ) u_skid (
    .i_clk   (rd_clk),
    .i_rst_n (areset_n),
    .i_push  (w_push),
    .i_data  (fifo_q),
    .i_pop   (w_pop),
    .o_occ   (w_occ),
    .o_valid (out_valid),
    .o_data  (out_data)
  );

  always_ff @(posedge rd_clk) begin
    if (!areset_n) r_state <= IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (enable) w_state_nxt = RUN;
      RUN:     if (!enable) w_state_nxt = DRAIN;
      // No reads are issued in DRAIN, so a zero credit means buffer and pipe
      // are both empty after this edge.
      DRAIN: begin
        if (enable)                w_state_nxt = RUN;
        else if (w_credit == '0)   w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign busy = (r_state != IDLE);

  // The index survives DRAIN/IDLE so a block can span an enable gap.
  assign w_last   = (r_idx == LAST_IDX);
  assign out_last = out_valid & w_last;

  always_ff @(posedge rd_clk) begin
    if (!areset_n) begin
      r_idx     <= '0;
      r_blk_cnt <= '0;
    end else if (w_pop) begin
      if (w_last) begin
        r_idx     <= '0;
        r_blk_cnt <= r_blk_cnt + CNTW'(1);
      end else begin
        r_idx <= r_idx + 16'd1;
      end
    end
  end

  assign blk_cnt = r_blk_cnt;

`ifdef DRAIN_STATS_EN
  logic [15:0] r_starve_cnt;

  always_ff @(posedge rd_clk) begin
    if (!areset_n || stats_clr) begin
      r_starve_cnt <= '0;
    end else if ((r_state == RUN) && out_ready && !out_valid && (r_starve_cnt != 16'hFFFF)) begin
      r_starve_cnt <= r_starve_cnt + 16'd1;
    end
  end

  assign starve_cnt = r_starve_cnt;
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fifo_drain_ctrl
// Directed bench for fifo_drain_ctrl. Two instances share clock and reset:
//   u_dut1 : RD_LAT=1, BLK_LEN=16 (burst, stalls, reset, enable gap, stats)
//   u_dut3 : RD_LAT=3, BLK_LEN=16 (random fifo_empty toggling)
// Each instance has a small FIFO model that returns 1,2,3,... in read order.
// The starve counter steps are compiled in only with DRAIN_STATS_EN.
// ----------------------------------------------------------------------------
module tb_fifo_drain_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // ---------------- instance 1 (RD_LAT=1) ----------------
  logic        en1, emp1, rd1, ov1, ordy1, ol1, busy1, emp_f1;
  logic [7:0]  q1 = 8'h00;
  logic [7:0]  od1;
  logic [15:0] bc1;
  int          rd_ptr1 = 0;
  int          wr1 = 0;
`ifdef DRAIN_STATS_EN
  logic        clr;
  logic [15:0] starve;
`endif

  assign emp1 = emp_f1 | (rd_ptr1 == wr1);

  fifo_drain_ctrl #(
    .DWIDTH (8), .RD_LAT (1), .BLK_LEN (16), .CNTW (16)
  ) u_dut1 (
    .rd_clk     (clk),
    .areset_n   (rst_n),
    .enable     (en1),
    .fifo_empty (emp1),
    .fifo_read  (rd1),
    .fifo_q     (q1),
    .out_valid  (ov1),
    .out_ready  (ordy1),
    .out_data   (od1),
    .out_last   (ol1),
    .blk_cnt    (bc1),
    .busy       (busy1)
`ifdef DRAIN_STATS_EN
    ,
    .stats_clr  (clr),
    .starve_cnt (starve)
`endif
  );

  always @(posedge clk) begin
    if (rd1) begin
      q1      <= 8'(rd_ptr1 + 1);
      rd_ptr1 <= rd_ptr1 + 1;
    end
  end

  // ---------------- instance 3 (RD_LAT=3) ----------------
  logic        en3, emp3, rd3, ov3, ordy3, ol3, busy3, emp_f3;
  logic [7:0]  q3 = 8'h00;
  logic [7:0]  p3_a = 8'h00;
  logic [7:0]  p3_b = 8'h00;
  logic [7:0]  od3;
  logic [15:0] bc3;
  int          rd_ptr3 = 0;
  int          wr3 = 0;

  assign emp3 = emp_f3 | (rd_ptr3 == wr3);

  fifo_drain_ctrl #(
    .DWIDTH (8), .RD_LAT (3), .BLK_LEN (16), .CNTW (16)
  ) u_dut3 (
    .rd_clk     (clk),
    .areset_n   (rst_n),
    .enable     (en3),
    .fifo_empty (emp3),
    .fifo_read  (rd3),
    .fifo_q     (q3),
    .out_valid  (ov3),
    .out_ready  (ordy3),
    .out_data   (od3),
    .out_last   (ol3),
    .blk_cnt    (bc3),
    .busy       (busy3)
`ifdef DRAIN_STATS_EN
    ,
    .stats_clr  (clr),
    .starve_cnt ()
`endif
  );

  // Three-stage RAM read pipe: data read in cycle t appears on q3 in t+3.
  always @(posedge clk) begin
    if (rd3) begin
      p3_a    <= 8'(rd_ptr3 + 1);
      rd_ptr3 <= rd_ptr3 + 1;
    end else begin
      p3_a <= 8'hEE;
    end
    p3_b <= p3_a;
    q3   <= p3_b;
  end

  // ---------------- monitors ----------------
  logic [8:0] pops1[$];
  logic [8:0] pops3[$];
  int         pc1[$];
  int         cyc = 0;
  int         outs1 = 0, outs3 = 0;
  int         viol_emp1 = 0, viol_cred1 = 0, viol_stab1 = 0;
  int         viol_emp3 = 0, viol_cred3 = 0;
  logic       stall1 = 1'b0;
  logic [8:0] hold1 = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      outs1  <= 0;
      stall1 <= 1'b0;
    end else begin
      if (rd1 && emp1) viol_emp1 <= viol_emp1 + 1;
      if (rd1 && (outs1 - int'(ov1 & ordy1)) >= 2) viol_cred1 <= viol_cred1 + 1;
      outs1 <= outs1 + int'(rd1) - int'(ov1 & ordy1);
      if (stall1 && !(ov1 && ({ol1, od1} == hold1))) viol_stab1 <= viol_stab1 + 1;
      stall1 <= ov1 & ~ordy1;
      hold1  <= {ol1, od1};
      if (ov1 && ordy1) begin
        pops1.push_back({ol1, od1});
        pc1.push_back(cyc);
      end
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      outs3 <= 0;
    end else begin
      if (rd3 && emp3) viol_emp3 <= viol_emp3 + 1;
      if (rd3 && (outs3 - int'(ov3 & ordy3)) >= 4) viol_cred3 <= viol_cred3 + 1;
      outs3 <= outs3 + int'(rd3) - int'(ov3 & ordy3);
      if (ov3 && ordy3) pops3.push_back({ol3, od3});
    end
  end

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  int v0, v1;

  initial begin
    rst_n = 1'b0; en1 = 1'b0; ordy1 = 1'b0; emp_f1 = 1'b0; wr1 = 32;
    en3 = 1'b0; ordy3 = 1'b1; emp_f3 = 1'b0; wr3 = 0;
`ifdef DRAIN_STATS_EN
    clr = 1'b0;
`endif
    repeat (2) @(negedge clk);

    // ---- reset state ----
    check("rst_valid", 32'(ov1), 32'd0);
    check("rst_last",  32'(ol1), 32'd0);
    check("rst_busy",  32'(busy1), 32'd0);
    check("rst_blk",   32'(bc1), 32'd0);
    check("rst_data",  32'(od1), 32'd0);
    check("rst_read",  32'(rd1), 32'd0);
    check("rst_busy3", 32'(busy3), 32'd0);

    // ---- T1: 32-sample burst, RD_LAT=1 ----
    rst_n = 1'b1; en1 = 1'b1; ordy1 = 1'b1;
    for (int i = 0; i < 8 && !rd1; i++) @(negedge clk);
    check("t1_first_rd", 32'(rd1), 32'd1);
    @(negedge clk);
    check("t1_lat_c1", 32'(ov1), 32'd0);
    @(negedge clk);
    check("t1_lat_c2", 32'(ov1), 32'd1);
    check("t1_first_data", 32'(od1), 32'h01);
    for (int i = 0; i < 60 && pops1.size() < 32; i++) @(negedge clk);
    check("t1_npops", 32'(pops1.size()), 32'd32);
    for (int i = 0; i < 32 && i < pops1.size(); i++) begin
      check($sformatf("t1_data%0d", i), 32'(pops1[i][7:0]), 32'(i + 1));
      check($sformatf("t1_last%0d", i), 32'(pops1[i][8]), 32'((i == 15) || (i == 31)));
    end
    if (pc1.size() >= 32) check("t1_consecutive", 32'(pc1[31] - pc1[0]), 32'd31);
    check("t1_blk", 32'(bc1), 32'd2);
    check("t1_busy", 32'(busy1), 32'd1);

    // ---- T2: out_ready 1,0,0,1 with stalls ----
    pops1.delete(); pc1.delete();
    wr1 = wr1 + 40;
    for (int i = 0; i < 120; i++) begin
      ordy1 = ((i % 4) == 0) || ((i % 4) == 3);
      @(negedge clk);
    end
    ordy1 = 1'b1;
    for (int i = 0; i < 60 && pops1.size() < 40; i++) @(negedge clk);
    check("t2_npops", 32'(pops1.size()), 32'd40);
    for (int i = 0; i < 40 && i < pops1.size(); i++) begin
      check($sformatf("t2_data%0d", i), 32'(pops1[i][7:0]), 32'(33 + i));
      check($sformatf("t2_last%0d", i), 32'(pops1[i][8]), 32'((i == 15) || (i == 31)));
    end
    check("t2_blk", 32'(bc1), 32'd4);
    check("t2_no_rd_empty", 32'(viol_emp1), 32'd0);
    check("t2_credit", 32'(viol_cred1), 32'd0);
    check("t2_stall_stable", 32'(viol_stab1), 32'd0);

    // ---- T3: reset mid-block with a read in flight ----
    pops1.delete(); pc1.delete();
    wr1 = rd_ptr1 + 20;
    for (int i = 0; i < 20 && pops1.size() < 5; i++) @(negedge clk);
    check("t3_rd_inflight", 32'(rd1), 32'd1);
    rst_n = 1'b0; en1 = 1'b0;
    @(negedge clk);
    check("t3_valid", 32'(ov1), 32'd0);
    check("t3_blk", 32'(bc1), 32'd0);
    check("t3_busy", 32'(busy1), 32'd0);
    check("t3_last", 32'(ol1), 32'd0);
    check("t3_data", 32'(od1), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t3_discard_valid", 32'(ov1), 32'd0);
    check("t3_discard_pops", 32'(pops1.size()), 32'd5);

    // ---- T4: enable gap after sample 5, block spans the gap ----
    pops1.delete(); pc1.delete();
    v0 = rd_ptr1 + 1;
    wr1 = rd_ptr1 + 40;
    en1 = 1'b1; ordy1 = 1'b1;
    for (int i = 0; i < 20 && pops1.size() < 4; i++) @(negedge clk);
    en1 = 1'b0;
    @(negedge clk);
    check("t4_drain_busy", 32'(busy1), 32'd1);
    check("t4_drain_no_rd", 32'(rd1), 32'd0);
    for (int i = 0; i < 10 && busy1; i++) @(negedge clk);
    check("t4_idle", 32'(busy1), 32'd0);
    check("t4_valid_low", 32'(ov1), 32'd0);
    check("t4_npops", 32'(pops1.size()), 32'd7);
    for (int i = 0; i < 7 && i < pops1.size(); i++)
      check($sformatf("t4_data%0d", i), 32'(pops1[i][7:0]), 32'(8'(v0 + i)));
    v1 = rd_ptr1 + 1;
    en1 = 1'b1;
    for (int i = 0; i < 40 && pops1.size() < 16; i++) @(negedge clk);
    check("t4_npops16", 32'(pops1.size()), 32'd16);
    if (pops1.size() >= 16) begin
      check("t4_resume_data", 32'(pops1[7][7:0]), 32'(8'(v1)));
      check("t4_last14", 32'(pops1[14][8]), 32'd0);
      check("t4_last15", 32'(pops1[15][8]), 32'd1);
    end
    check("t4_blk", 32'(bc1), 32'd1);
    en1 = 1'b0;
    for (int i = 0; i < 10 && busy1; i++) @(negedge clk);

    // ---- T5: RD_LAT=3 with random fifo_empty ----
    wr3 = 40; en3 = 1'b1;
    for (int i = 0; i < 150; i++) begin
      emp_f3 = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    emp_f3 = 1'b0;
    for (int i = 0; i < 100 && pops3.size() < 40; i++) @(negedge clk);
    check("t5_npops", 32'(pops3.size()), 32'd40);
    for (int i = 0; i < 40 && i < pops3.size(); i++)
      check($sformatf("t5_data%0d", i), 32'(pops3[i][7:0]), 32'(i + 1));
    check("t5_no_rd_empty", 32'(viol_emp3), 32'd0);
    check("t5_credit", 32'(viol_cred3), 32'd0);
    check("t5_blk", 32'(bc3), 32'd2);
    en3 = 1'b0;

`ifdef DRAIN_STATS_EN
    // ---- T6: starve counter ----
    wr1 = rd_ptr1;
    en1 = 1'b1; ordy1 = 1'b1;
    repeat (3) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("t6_cleared", 32'(starve), 32'd0);
    repeat (10) @(negedge clk);
    check("t6_count10", 32'(starve), 32'd10);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("t6_clr_pulse", 32'(starve), 32'd0);
    en1 = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
